// File: rtl/uart_rx_oversampler.sv
// 16x-oversampling UART receiver: 2-flop input synchronizer, baud tick divider,
// 3-sample majority vote per bit, glitch-start rejection and break-safe re-arm.
module uart_rx_oversampler #(
  parameter int DIV_9600   = 326,
  parameter int DIV_57600  = 54,
  parameter int DIV_115200 = 27,
  parameter int DIV_W      = 9
) (
  input  logic       src_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] baud_sel,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta, rx_s, rx_s_d;
  logic [1:0]       baud_q;
  logic [DIV_W-1:0] div_cnt, div_val;
  logic             tick;
  logic [3:0]       sample_cnt;
  logic [2:0]       bit_cnt;
  logic             vote7, vote8;
  logic [7:0]       shift;
  logic             armed, hi_ok;
  logic             start_edge, decide, wrap, maj;
  logic             load_data, flag_err;

  always_comb begin
    case (baud_q)
      2'b00:   div_val = DIV_W'(DIV_9600);
      2'b01:   div_val = DIV_W'(DIV_57600);
      default: div_val = DIV_W'(DIV_115200);
    endcase
  end

  // >= rather than == so a divisor shrink while idle cannot strand the counter.
  assign tick       = (div_cnt >= div_val - DIV_W'(1));
  assign start_edge = (state_q == IDLE) && enable && armed && rx_s_d && !rx_s;
  assign decide     = tick && (sample_cnt == 4'd9);
  assign wrap       = tick && (sample_cnt == 4'd15);
  assign maj        = (vote7 & vote8) | (vote7 & rx_s) | (vote8 & rx_s);
  assign busy       = (state_q != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    load_data = 1'b0;
    flag_err  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge) state_d = START;
        end
        START: begin
          if (decide && maj) state_d = IDLE;
          else if (wrap)     state_d = DATA;
        end
        DATA: begin
          if (wrap && (bit_cnt == 3'd7)) state_d = STOP;
        end
        STOP: begin
          if (decide) begin
            state_d = IDLE;
            if (maj) load_data = 1'b1;
            else     flag_err  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_s_d     <= 1'b1;
      baud_q     <= 2'b00;
      div_cnt    <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      vote7      <= 1'b0;
      vote8      <= 1'b0;
      shift      <= '0;
      armed      <= 1'b1;
      hi_ok      <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every flop samples pre-edge values together.
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_s_d     <= rx_s;
      state_q    <= state_d;
      data_valid <= load_data;
      frame_err  <= flag_err;
      if (load_data) data <= shift;

      if (state_q == IDLE) baud_q <= baud_sel;

      if (start_edge || tick) div_cnt <= '0;
      else                    div_cnt <= div_cnt + DIV_W'(1);

      if (state_q == IDLE) sample_cnt <= '0;
      else if (tick)       sample_cnt <= sample_cnt + 4'd1;

      if (tick && (sample_cnt == 4'd7)) vote7 <= rx_s;
      if (tick && (sample_cnt == 4'd8)) vote8 <= rx_s;

      if (state_q != DATA) bit_cnt <= '0;
      else if (wrap)       bit_cnt <= bit_cnt + 3'd1;

      if ((state_q == DATA) && decide) shift <= {maj, shift[7:1]};

      // hi_ok tracks whether rx_s stayed high across the current tick window.
      if (tick)       hi_ok <= rx_s;
      else if (!rx_s) hi_ok <= 1'b0;

      if (flag_err)                 armed <= 1'b0;
      else if (tick && hi_ok && rx_s) armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler with shortened divisors (10/6/3 clocks per tick)
// so full frames at every rate fit in a short run.
module tb_uart_rx_oversampler;

  localparam int BC_SLOW = 160;  // clocks per bit at "9600" (16 * 10)
  localparam int BC_FAST = 48;   // clocks per bit at "115200" (16 * 3)

  logic       src_clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] baud_sel = 2'b00;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid, frame_err, busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int n_err = 0;
  int n_both = 0;
  logic [7:0] vdata[$];
  int         vcyc[$];

  uart_rx_oversampler #(
    .DIV_9600(10), .DIV_57600(6), .DIV_115200(3), .DIV_W(9)
  ) dut (
    .src_clk(src_clk), .rst(rst), .enable(enable), .baud_sel(baud_sel), .rx(rx),
    .data(data), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 src_clk = ~src_clk;
  always @(posedge src_clk) cyc++;

  always @(negedge src_clk) begin
    if (data_valid) begin
      vdata.push_back(data);
      vcyc.push_back(cyc);
    end
    if (frame_err) n_err++;
    if (data_valid && frame_err) n_both++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] vd(input int i);
    return (vdata.size() > i) ? 32'(vdata[i]) : 32'h1FF;
  endfunction

  // Must be called on a negedge; drives the first nbits of {stop, b, start}.
  task automatic drive_frame(input logic [7:0] b, input int bc, input logic stop_v,
                             input int nbits);
    logic [9:0] f;
    f = {stop_v, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = f[i];
      if (i == 0) start_cyc = cyc;
      repeat (bc) @(negedge src_clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge src_clk);
  endtask

  int lat;
  int nv;

  initial begin
    repeat (3) @(negedge src_clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(40);

    // 9600: single 0x52, latency about 2 + 154 ticks (1543 clocks) within a tick
    drive_frame(8'h52, BC_SLOW, 1'b1, 10);
    idle(40);
    check("t1_count", 32'(vdata.size()), 32'd1);
    check("t1_data", vd(0), 32'h52);
    lat = (vcyc.size() > 0) ? vcyc[0] - start_cyc : -1;
    check("t1_latency", 32'((lat >= 1533) && (lat <= 1553)), 32'd1);
    check("t1_ferr", 32'(n_err), 32'd0);

    // 115200: two back-to-back 0x5A frames with no idle gap
    baud_sel = 2'b10;
    idle(40);
    drive_frame(8'h5A, BC_FAST, 1'b1, 10);
    drive_frame(8'h5A, BC_FAST, 1'b1, 10);
    idle(40);
    check("t2_count", 32'(vdata.size()), 32'd3);
    check("t2_data0", vd(1), 32'h5A);
    check("t2_data1", vd(2), 32'h5A);
    check("t2_ferr", 32'(n_err), 32'd0);

    // 9600: short low glitch is a false start
    baud_sel = 2'b00;
    idle(40);
    rx = 1'b0;
    repeat (6) @(negedge src_clk);
    check("t3_busy_up", 32'(busy), 32'd1);
    repeat (24) @(negedge src_clk);
    idle(150);
    check("t3_busy_down", 32'(busy), 32'd0);
    check("t3_count", 32'(vdata.size()), 32'd3);
    check("t3_data", 32'(data), 32'h5A);

    // bad stop bit then a break; re-arm needs a full high tick
    drive_frame(8'hA5, BC_SLOW, 1'b0, 10);
    rx = 1'b0;
    repeat (3000) @(negedge src_clk);
    check("t4_ferr", 32'(n_err), 32'd1);
    check("t4_data", 32'(data), 32'h5A);
    check("t4_nostart_low", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (2) @(negedge src_clk);
    rx = 1'b0;
    repeat (8) @(negedge src_clk);
    check("t4_unarmed", 32'(busy), 32'd0);
    repeat (32) @(negedge src_clk);
    idle(200);
    drive_frame(8'h33, BC_SLOW, 1'b1, 10);
    idle(40);
    check("t4_count", 32'(vdata.size()), 32'd4);
    check("t4_data33", vd(3), 32'h33);
    check("t4_ferr_once", 32'(n_err), 32'd1);

    // synchronous reset in the middle of bit 4
    drive_frame(8'h52, BC_SLOW, 1'b1, 5);
    rx = 1'b1;
    repeat (80) @(negedge src_clk);
    rst = 1'b1;
    @(negedge src_clk);
    check("t5_rst_data", 32'(data), 32'h00);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_pulse", 32'(data_valid | frame_err), 32'd0);
    rst = 1'b0;
    idle(2000);
    check("t5_no_pulse", 32'(vdata.size()), 32'd4);
    drive_frame(8'h52, BC_SLOW, 1'b1, 10);
    idle(40);
    check("t5_data", vd(4), 32'h52);

    // enable drop during bit 3 aborts the frame
    drive_frame(8'h52, BC_SLOW, 1'b1, 4);
    rx = 1'b0;
    repeat (80) @(negedge src_clk);
    enable = 1'b0;
    @(negedge src_clk);
    check("t6_abort_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge src_clk);
    enable = 1'b1;
    idle(2000);
    check("t6_no_pulse", 32'(vdata.size()), 32'd5);
    check("t6_data_kept", 32'(data), 32'h52);
    check("t6_ferr", 32'(n_err), 32'd1);

    // baud_sel change mid-frame only takes effect at the next idle
    fork
      drive_frame(8'hC3, BC_SLOW, 1'b1, 10);
      begin
        repeat (560) @(negedge src_clk);
        baud_sel = 2'b10;
      end
    join
    idle(100);
    check("t7_slow_data", vd(5), 32'hC3);
    drive_frame(8'h3C, BC_FAST, 1'b1, 10);
    idle(40);
    nv = vdata.size();
    check("t7_count", 32'(nv), 32'd7);
    check("t7_fast_data", vd(6), 32'h3C);
    check("t7_ferr", 32'(n_err), 32'd1);
    check("never_both", 32'(n_both), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
